jtframe_sdram_stats_mon: RTL and testbench

//  Synthesizable, parametrised SDRAM command-bus monitor, successor to the simulation-only stats block.

---
 rtl/jtframe_sdram_stats_mon_if.sv | 25 ++
 rtl/jtframe_sdram_stats_mon.sv | 99 +++++++++
 tb/tb_jtframe_sdram_stats_mon.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_sdram_stats_mon_if.sv
// jtframe_sdram_stats_mon_if: snooped SDRAM command bus plus the stats read port
interface jtframe_sdram_stats_mon_if #(parameter int CW = 16);
  logic [12:0]   sdram_a;
  logic [1:0]    sdram_ba;
  logic          sdram_ncs;
  logic          sdram_nras;
  logic          sdram_ncas;
  logic          sdram_nwe;
  logic          freeze;
  logic [1:0]    st_bank;
  logic [2:0]    st_field;
  logic [CW-1:0] st_dout;
  logic          win_done;
  logic [7:0]    win_cnt;
  modport master (
    output sdram_a, sdram_ba, sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe,
    output freeze, st_bank, st_field,
    input  st_dout, win_done, win_cnt
  );
  modport slave (
    input  sdram_a, sdram_ba, sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe,
    input  freeze, st_bank, st_field,
    output st_dout, win_done, win_cnt
  );
endinterface

// File: rtl/jtframe_sdram_stats_mon.sv
// jtframe_sdram_stats_mon: passive per-bank SDRAM command statistics over fixed windows
module jtframe_sdram_stats_mon #(
  parameter int BANKS = 4,
  parameter int CW    = 16,
  parameter int WIN   = 1000000
) (
  input logic clk,
  input logic rst,
  jtframe_sdram_stats_mon_if.slave bus
);
  localparam int WW = $clog2(WIN);
  typedef logic [CW-1:0] cnt_t;

  function automatic cnt_t sat(cnt_t x);
    return &x ? x : x + 1'b1;
  endfunction

  // a boundary-cycle event starts the new window at 1 instead of 0
  function automatic cnt_t nxt(cnt_t cur, logic inc, logic clr);
    return inc ? sat(clr ? '0 : cur) : (clr ? '0 : cur);
  endfunction

  logic [3:0] cmd;
  logic       is_act, is_rd, is_wr, is_ref, is_lm, bnd;
  logic [WW-1:0] wcnt;
  cnt_t live_ref, sh_ref;
  logic [7:0][CW-1:0] shv [4];

  assign cmd    = {bus.sdram_ncs, bus.sdram_nras, bus.sdram_ncas, bus.sdram_nwe};
  assign is_act = cmd == 4'b0011;
  assign is_rd  = cmd == 4'b0101;
  assign is_wr  = cmd == 4'b0100;
  assign is_ref = cmd == 4'b0001;
  assign is_lm  = cmd == 4'b0000;
  assign bnd    = wcnt == WW'(WIN - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt         <= '0;
      live_ref     <= '0;
      sh_ref       <= '0;
      bus.win_done <= 1'b0;
      bus.win_cnt  <= '0;
      bus.st_dout  <= '0;
    end else begin
      wcnt         <= bnd ? '0 : wcnt + 1'b1;
      live_ref     <= nxt(live_ref, is_ref, bnd);
      if (bnd && !bus.freeze) sh_ref <= live_ref;
      bus.win_done <= bnd;
      bus.win_cnt  <= bus.win_cnt + 8'(bnd);
      bus.st_dout  <= shv[bus.st_bank][bus.st_field];
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    if (b < BANKS) begin : g_on
      cnt_t act, same, lng, rd, wr, run, s_act, s_same, s_lng, s_rd, s_wr, run_n, lng_b;
      logic [12:0] row;
      logic vld, hit, act_hit, same_hit;
      assign hit      = bus.sdram_ba == 2'(b);
      assign act_hit  = is_act && hit;
      assign same_hit = vld && bus.sdram_a == row;
      assign run_n    = same_hit ? sat(run) : cnt_t'(1);
      assign lng_b    = bnd ? '0 : lng;
      always_ff @(posedge clk) begin
        if (rst) begin
          {act, same, lng, rd, wr, run} <= '0;
          {s_act, s_same, s_lng, s_rd, s_wr} <= '0;
          row <= '0;
          vld <= 1'b0;
        end else begin
          act  <= nxt(act, act_hit, bnd);
          same <= nxt(same, act_hit && same_hit, bnd);
          rd   <= nxt(rd, is_rd && hit, bnd);
          wr   <= nxt(wr, is_wr && hit, bnd);
          lng  <= act_hit && run_n > lng_b ? run_n : lng_b;
          if (act_hit) begin
            run <= run_n;
            row <= bus.sdram_a;
            vld <= 1'b1;
          end else if (is_lm) begin
            run <= '0;
            vld <= 1'b0;
          end
          if (bnd && !bus.freeze) begin
            s_act  <= act;
            s_same <= same;
            s_lng  <= lng;
            s_rd   <= rd;
            s_wr   <= wr;
          end
        end
      end
      assign shv[b] = {cnt_t'(0), cnt_t'(0), sh_ref, s_wr, s_rd, s_lng, s_same, s_act};
    end else begin : g_off
      assign shv[b] = '0;
    end
  end
endmodule

// File: tb/tb_jtframe_sdram_stats_mon.sv
// tb_jtframe_sdram_stats_mon: directed tables plus random traffic against a window-level model
module tb_jtframe_sdram_stats_mon;
  localparam int WIN = 48;
  localparam logic [3:0] C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
  localparam logic [3:0] C_REF = 4'b0001, C_LM = 4'b0000, C_NOP = 4'b0111;

  typedef struct { logic [3:0] cmd; logic [1:0] ba; logic [12:0] a; } ev_t;
  typedef struct { int stage; int bank; int field; int e0; int e1; } rd_t;

  logic clk = 0, rst = 1;
  logic [3:0] cmd = C_NOP;
  logic [1:0] ba = 0, st_bank = 0;
  logic [12:0] a = 0;
  logic [2:0] st_field = 0;
  logic freeze = 0;
  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  jtframe_sdram_stats_mon_if #(.CW(16)) if0();
  jtframe_sdram_stats_mon_if #(.CW(4))  if1();

  assign {if0.sdram_ncs, if0.sdram_nras, if0.sdram_ncas, if0.sdram_nwe} = cmd;
  assign {if1.sdram_ncs, if1.sdram_nras, if1.sdram_ncas, if1.sdram_nwe} = cmd;
  assign if0.sdram_a = a;        assign if1.sdram_a = a;
  assign if0.sdram_ba = ba;      assign if1.sdram_ba = ba;
  assign if0.freeze = freeze;    assign if1.freeze = freeze;
  assign if0.st_bank = st_bank;  assign if1.st_bank = st_bank;
  assign if0.st_field = st_field; assign if1.st_field = st_field;

  jtframe_sdram_stats_mon #(.BANKS(4), .CW(16), .WIN(WIN)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  jtframe_sdram_stats_mon #(.BANKS(3), .CW(4),  .WIN(WIN)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // model: commands of the open window are queued and evaluated when it closes
  ev_t q[$];
  int wc, wincnt, exp_done;
  int exp_dout [2];
  int shadow [2][4][8];
  int prow [2][4];
  int prun [2][4];
  bit pvld [2][4];

  function automatic int nb(int c); return c == 0 ? 4 : 3; endfunction
  function automatic int sat(int c, int v);
    int m;
    m = c == 0 ? 65535 : 15;
    return v > m ? m : v;
  endfunction

  function automatic void close_window(bit frz);
    for (int c = 0; c < 2; c++) begin
      int st [4][8];
      int r;
      r = 0;
      for (int b = 0; b < 4; b++) for (int f = 0; f < 8; f++) st[b][f] = 0;
      foreach (q[i]) begin
        int b;
        b = int'(q[i].ba);
        if (q[i].cmd == C_REF) r++;
        else if (q[i].cmd == C_LM) begin
          for (int k = 0; k < 4; k++) begin pvld[c][k] = 0; prun[c][k] = 0; end
        end else if (b < nb(c)) begin
          if (q[i].cmd == C_RD) st[b][3]++;
          else if (q[i].cmd == C_WR) st[b][4]++;
          else begin
            st[b][0]++;
            if (pvld[c][b] && prow[c][b] == int'(q[i].a)) begin st[b][1]++; prun[c][b]++; end
            else prun[c][b] = 1;
            prow[c][b] = int'(q[i].a);
            pvld[c][b] = 1;
            if (prun[c][b] > st[b][2]) st[b][2] = prun[c][b];
          end
        end
      end
      if (!frz)
        for (int b = 0; b < 4; b++)
          for (int f = 0; f < 8; f++)
            shadow[c][b][f] = (b >= nb(c) || f > 5) ? 0 : f == 5 ? sat(c, r) : sat(c, st[b][f]);
    end
    q.delete();
  endfunction

  function automatic void model_edge();
    if (rst) begin
      wc = 0; wincnt = 0; exp_done = 0; q.delete();
      for (int c = 0; c < 2; c++) begin
        exp_dout[c] = 0;
        for (int b = 0; b < 4; b++) begin
          prow[c][b] = 0; prun[c][b] = 0; pvld[c][b] = 0;
          for (int f = 0; f < 8; f++) shadow[c][b][f] = 0;
        end
      end
    end else begin
      for (int c = 0; c < 2; c++) exp_dout[c] = shadow[c][int'(st_bank)][int'(st_field)];
      exp_done = wc == WIN - 1 ? 1 : 0;
      if (exp_done == 1) begin
        close_window(freeze);
        wincnt = (wincnt + 1) % 256;
      end
      if (cmd inside {C_ACT, C_RD, C_WR, C_REF, C_LM}) q.push_back('{cmd, ba, a});
      wc = exp_done == 1 ? 0 : wc + 1;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("dout0", 32'(if0.st_dout), exp_dout[0]);
    chk("dout1", 32'(if1.st_dout), exp_dout[1]);
    chk("done0", 32'(if0.win_done), exp_done);
    chk("done1", 32'(if1.win_done), exp_done);
    chk("wcnt0", 32'(if0.win_cnt), wincnt);
    chk("wcnt1", 32'(if1.win_cnt), wincnt);
  endtask

  task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] aa);
    cmd = c; ba = b; a = aa;
    step();
    cmd = C_NOP;
  endtask

  task automatic to_boundary();
    for (int i = 0; i < WIN && wc != WIN - 1; i++) step();
  endtask

  rd_t tab [24] = '{
    '{0,1,0,3,3}, '{0,1,1,2,2}, '{0,1,2,3,3}, '{0,0,0,6,6}, '{0,0,1,3,3}, '{0,0,2,3,3},
    '{0,2,3,20,15}, '{0,3,0,2,0}, '{0,3,1,0,0}, '{0,3,2,1,0}, '{0,0,5,0,0}, '{0,2,4,0,0},
    '{1,2,4,1,1}, '{1,0,5,3,3}, '{1,1,0,0,0}, '{1,2,3,0,0}, '{1,3,5,3,0},
    '{2,2,4,1,1}, '{2,0,5,3,3},
    '{3,0,5,2,2}, '{3,2,4,0,0},
    '{4,0,0,2,2}, '{4,0,1,1,1}, '{4,0,2,2,2}
  };

  task automatic read_stage(input int s);
    foreach (tab[i]) if (tab[i].stage == s) begin
      st_bank = 2'(tab[i].bank);
      st_field = 3'(tab[i].field);
      step();
      chk($sformatf("tab%0d_b%0d_f%0d_d0", s, tab[i].bank, tab[i].field), 32'(if0.st_dout), tab[i].e0);
      chk($sformatf("tab%0d_b%0d_f%0d_d1", s, tab[i].bank, tab[i].field), 32'(if1.st_dout), tab[i].e1);
    end
  endtask

  logic [3:0] codes [10] = '{C_ACT, C_ACT, C_ACT, C_RD, C_WR, C_REF, C_NOP, 4'b1011, 4'b0110, 4'b0010};

  initial begin
    int n;
    step(); step();
    rst = 0;
    // window A: same-row runs, saturation, LOAD_MODE, ignored bank
    for (int i = 0; i < 3; i++) issue(C_ACT, 1, 13'h055);
    foreach (tab[i]) ;
    issue(C_ACT, 0, 5); issue(C_ACT, 0, 5); issue(C_ACT, 0, 7);
    issue(C_ACT, 0, 7); issue(C_ACT, 0, 7); issue(C_ACT, 0, 5);
    for (int i = 0; i < 20; i++) issue(C_RD, 2, 0);
    issue(C_ACT, 3, 9); issue(C_LM, 0, 0); issue(C_ACT, 3, 9);
    to_boundary();
    issue(C_WR, 2, 0);
    chk("a_done_pulse", 32'(if0.win_done), 1);
    chk("a_win_cnt", 32'(if0.win_cnt), 1);
    // window B
    read_stage(0);
    chk("a_done_single", 32'(if0.win_done), 0);
    for (int i = 0; i < 3; i++) issue(C_REF, 0, 0);
    to_boundary();
    step();
    // window C: frozen close
    read_stage(1);
    for (int i = 0; i < 4; i++) issue(C_REF, 1, 0);
    to_boundary();
    freeze = 1;
    step();
    freeze = 0;
    chk("c_win_cnt_frozen", 32'(if1.win_cnt), 3);
    // window D
    read_stage(2);
    issue(C_REF, 2, 0); issue(C_REF, 3, 0);
    to_boundary();
    step();
    chk("d_win_cnt", 32'(if0.win_cnt), 4);
    // window E: reset mid-window
    read_stage(3);
    for (int i = 0; i < 10; i++) issue(C_ACT, 0, 1);
    rst = 1;
    step();
    chk("rst_dout", 32'(if0.st_dout), 0);
    chk("rst_done", 32'(if0.win_done), 0);
    chk("rst_wcnt", 32'(if1.win_cnt), 0);
    rst = 0;
    issue(C_ACT, 0, 4); issue(C_ACT, 0, 4);
    n = 2;
    while (if0.win_done !== 1'b1 && n < 2 * WIN) begin step(); n++; end
    chk("rst_win_len", n, WIN);
    read_stage(4);
    // random traffic with random freeze, read selects and an occasional reset
    for (int i = 0; i < 8 * WIN; i++) begin
      cmd = $urandom_range(0, 29) == 0 ? C_LM : codes[$urandom_range(0, 9)];
      ba = 2'($urandom_range(0, 3));
      a = 13'($urandom_range(0, 3));
      freeze = $urandom_range(0, 3) == 0;
      st_bank = 2'($urandom_range(0, 3));
      st_field = 3'($urandom_range(0, 7));
      rst = i == 5 * WIN + 17;
      step();
    end
    rst = 0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
